// File: rtl/tetris_io_pkg.sv
// Shared definitions for the Tetris button front end: channel states,
// key indices and default sampling-tick constants.
package tetris_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } key_state_e;

    localparam int KEY_LEFT  = 0;
    localparam int KEY_RIGHT = 1;
    localparam int KEY_ROT   = 2;
    localparam int KEY_DROP  = 3;

    localparam int DEF_DEBOUNCE_TICKS = 4;
    localparam int DEF_REPEAT_DELAY   = 16;
    localparam int DEF_REPEAT_RATE    = 4;

    // Width needed to hold 0..max(a,b).
    function automatic int cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key: tick-gated debouncer feeding a press / auto-repeat state machine.
module key_channel
    import tetris_io_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE    = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sample,
    output logic level,
    output logic press,
    output logic repeat_pulse
);

    localparam int DW = cnt_w(DEBOUNCE_TICKS, 1);
    localparam int RW = cnt_w(REPEAT_DELAY, REPEAT_RATE);

    key_state_e    state, state_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt, dcnt_inc;
    logic [RW-1:0] rcnt, rcnt_nxt, rcnt_inc;
    logic          level_nxt, press_nxt, rpt_nxt;
    logic          flip, rise, fall;

    // The edge is decided in the tick cycle itself so the FSM reacts together with the level.
    always_comb begin
        dcnt_inc = dcnt + 1'b1;
        rcnt_inc = rcnt + 1'b1;
        flip     = tick && (sample != level) && (dcnt_inc == DW'(DEBOUNCE_TICKS));
        rise     = flip && !level;
        fall     = flip && level;
    end

    always_comb begin
        dcnt_nxt  = dcnt;
        level_nxt = level;
        state_nxt = state;
        rcnt_nxt  = rcnt;
        press_nxt = 1'b0;
        rpt_nxt   = 1'b0;
        if (tick) begin
            if (sample == level) begin
                dcnt_nxt = '0;
            end else if (flip) begin
                level_nxt = ~level;
                dcnt_nxt  = '0;
            end else begin
                dcnt_nxt = dcnt_inc;
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        press_nxt = 1'b1;
                        rcnt_nxt  = '0;
                        state_nxt = DELAY;
                    end
                end
                DELAY: begin
                    if (fall) begin
                        rcnt_nxt  = '0;
                        state_nxt = IDLE;
                    end else if (rcnt_inc == RW'(REPEAT_DELAY)) begin
                        rpt_nxt   = 1'b1;
                        rcnt_nxt  = '0;
                        state_nxt = REPEAT;
                    end else begin
                        rcnt_nxt = rcnt_inc;
                    end
                end
                REPEAT: begin
                    // A fall wins over a repeat due on the same tick.
                    if (fall) begin
                        rcnt_nxt  = '0;
                        state_nxt = IDLE;
                    end else if (rcnt_inc == RW'(REPEAT_RATE)) begin
                        rpt_nxt  = 1'b1;
                        rcnt_nxt = '0;
                    end else begin
                        rcnt_nxt = rcnt_inc;
                    end
                end
                default: begin
                    rcnt_nxt  = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            dcnt         <= '0;
            rcnt         <= '0;
            level        <= 1'b0;
            press        <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            dcnt         <= dcnt_nxt;
            rcnt         <= rcnt_nxt;
            level        <= level_nxt;
            press        <= press_nxt;
            repeat_pulse <= rpt_nxt;
        end
    end

endmodule

// File: rtl/key_repeat_debouncer.sv
// Button front end: synchronizes the raw keys and the divided clock, turns
// clk_N rising edges into one-cycle ticks, and runs one key_channel per key.
module key_repeat_debouncer
    import tetris_io_pkg::*;
#(
    parameter int NKEYS          = 4,
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE    = DEF_REPEAT_RATE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_N,
    input  logic [NKEYS-1:0] keys_raw,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_repeat
);

    logic             clkn_p0, clkn_p1, clkn_p2;
    logic [NKEYS-1:0] keys_p0, keys_p1;
    logic             tick;

    // clk_N is only data here: two flops to synchronize, a third to find its rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkn_p0 <= 1'b0;
            clkn_p1 <= 1'b0;
            clkn_p2 <= 1'b0;
            keys_p0 <= '0;
            keys_p1 <= '0;
        end else begin
            clkn_p0 <= clk_N;
            clkn_p1 <= clkn_p0;
            clkn_p2 <= clkn_p1;
            keys_p0 <= keys_raw;
            keys_p1 <= keys_p0;
        end
    end

    assign tick = clkn_p1 & ~clkn_p2;

    for (genvar i = 0; i < NKEYS; i++) begin : gen_ch
        key_channel #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_RATE   (REPEAT_RATE)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick),
            .sample      (keys_p1[i]),
            .level       (key_level[i]),
            .press       (key_press[i]),
            .repeat_pulse(key_repeat[i])
        );
    end

endmodule

// File: tb/tb_key_repeat_debouncer.sv
// Bench for key_repeat_debouncer: a tick-level behavioural model queues the
// expected outputs for every clk_N edge, which are then compared to the DUT.
module tb_key_repeat_debouncer;

    localparam int DT = 4;
    localparam int RD = 16;
    localparam int RR = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_N = 1'b0;
    logic [3:0] keys_raw = 4'b0000;
    logic [3:0] key_level, key_press, key_repeat;

    key_repeat_debouncer #(
        .NKEYS(4), .DEBOUNCE_TICKS(DT), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_N     (clk_N),
        .keys_raw  (keys_raw),
        .key_level (key_level),
        .key_press (key_press),
        .key_repeat(key_repeat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] press;
        logic [3:0] rpt;
        logic [3:0] lvl;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    bit m_lvl[4];
    int m_dcnt[4];
    int m_st[4];
    int m_rcnt[4];

    int press_at;
    int rep_cnt[4];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_lvl[k] = 1'b0; m_dcnt[k] = 0; m_st[k] = 0; m_rcnt[k] = 0; rep_cnt[k] = 0;
        end
    endtask

    task automatic model_tick(input logic [3:0] s, output exp_t e);
        bit rise, fall;
        e.press = 4'b0; e.rpt = 4'b0;
        for (int k = 0; k < 4; k++) begin
            rise = 1'b0; fall = 1'b0;
            if (s[k] == m_lvl[k]) m_dcnt[k] = 0;
            else if (m_dcnt[k] + 1 == DT) begin
                rise = !m_lvl[k]; fall = m_lvl[k];
                m_lvl[k] = !m_lvl[k]; m_dcnt[k] = 0;
            end else m_dcnt[k]++;
            case (m_st[k])
                0: if (rise) begin e.press[k] = 1'b1; m_rcnt[k] = 0; m_st[k] = 1; end
                1: if (fall) begin m_rcnt[k] = 0; m_st[k] = 0; end
                   else if (m_rcnt[k] + 1 == RD) begin e.rpt[k] = 1'b1; m_rcnt[k] = 0; m_st[k] = 2; end
                   else m_rcnt[k]++;
                default: if (fall) begin m_rcnt[k] = 0; m_st[k] = 0; end
                   else if (m_rcnt[k] + 1 == RR) begin e.rpt[k] = 1'b1; m_rcnt[k] = 0; end
                   else m_rcnt[k]++;
            endcase
            e.lvl[k] = m_lvl[k];
        end
    endtask

    // One clk_N period with the keys applied; outputs watched on falling clk edges.
    task automatic tick_step(input logic [3:0] keys);
        exp_t e;
        logic [3:0] obs_p, obs_r, wide, prev_p, prev_r;
        keys_raw = keys;
        model_tick(keys, e);
        sb.push_back(e);
        repeat (3) @(negedge clk);
        clk_N = 1'b1;
        obs_p = '0; obs_r = '0; wide = '0; prev_p = '0; prev_r = '0;
        press_at = -1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (key_press != 4'b0 && press_at < 0) press_at = c;
            wide   |= (key_press & prev_p) | (key_repeat & prev_r);
            obs_p  |= key_press;
            obs_r  |= key_repeat;
            prev_p  = key_press;
            prev_r  = key_repeat;
            if (c == 6) clk_N = 1'b0;
        end
        for (int k = 0; k < 4; k++) if (obs_r[k]) rep_cnt[k]++;
        e = sb.pop_front();
        total++;
        if (obs_p !== e.press) begin
            bad++; $display("FAIL press: got %b want %b", obs_p, e.press);
        end
        total++;
        if (obs_r !== e.rpt) begin
            bad++; $display("FAIL repeat: got %b want %b", obs_r, e.rpt);
        end
        total++;
        if (key_level !== e.lvl) begin
            bad++; $display("FAIL level: got %b want %b", key_level, e.lvl);
        end
        total++;
        if (wide !== 4'b0) begin
            bad++; $display("FAIL pulse_width: multi-cycle bits %b want 0000", wide);
        end
    endtask

    task automatic apply_reset(input logic [3:0] keys);
        keys_raw = keys;
        clk_N = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        sb.delete();
    endtask

    task automatic test_reset();
        keys_raw = 4'b0001;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({key_level, key_press, key_repeat} !== 12'b0) begin
            bad++; $display("FAIL reset_outputs: got %b want 0", {key_level, key_press, key_repeat});
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_first_press();
        for (int t = 1; t <= 4; t++) tick_step(4'b0001);
        total++;
        if (press_at !== 3) begin
            bad++; $display("FAIL press_latency: got %0d want 3", press_at);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] pat [6] = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
        apply_reset(4'b0000);
        for (int t = 0; t < 6; t++) tick_step(pat[t]);
    endtask

    task automatic test_repeat_train();
        apply_reset(4'b0000);
        for (int t = 1; t <= 40; t++) tick_step(4'b0100);
        total++;
        if (rep_cnt[2] !== 6) begin
            bad++; $display("FAIL repeat_count: got %0d want 6", rep_cnt[2]);
        end
    endtask

    task automatic test_release_priority();
        for (int t = 1; t <= 4; t++) tick_step(4'b0000);
        total++;
        if (rep_cnt[2] !== 6 || key_level[2] !== 1'b0) begin
            bad++; $display("FAIL release_suppress: repeats %0d level %b want 6 0", rep_cnt[2], key_level[2]);
        end
        for (int t = 1; t <= 4; t++) tick_step(4'b0100);
    endtask

    task automatic test_back_to_back();
        apply_reset(4'b0000);
        for (int t = 1; t <= 28; t++) tick_step(4'b1001);
        total++;
        if (rep_cnt[0] !== 3 || rep_cnt[3] !== 3 || rep_cnt[1] !== 0) begin
            bad++; $display("FAIL dual_repeats: got %0d/%0d/%0d want 3/3/0", rep_cnt[0], rep_cnt[3], rep_cnt[1]);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset(4'b0000);
        for (int t = 1; t <= 8; t++) tick_step(4'b0001);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({key_level, key_press, key_repeat} !== 12'b0) begin
            bad++; $display("FAIL midreset_outputs: got %b want 0", {key_level, key_press, key_repeat});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int t = 1; t <= 4; t++) tick_step(4'b0001);
        total++;
        if (press_at !== 3) begin
            bad++; $display("FAIL repress_latency: got %0d want 3", press_at);
        end
    endtask

    initial begin
        test_reset();
        test_first_press();
        test_bounce();
        test_repeat_train();
        test_release_priority();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_repeat_debouncer.md
Name: key_repeat_debouncer

Overview:
Consumes the slow divided clock `clk_N` from the clock divider as a sampling strobe, not as a clock. Debounces the raw Tetris push-buttons (left, right, rotate, drop) on that strobe. Emits a clean level, a one-cycle press pulse and auto-repeat pulses per key, all in the system clock domain. Sits between the board button pins and the game-control logic / MIPS IO register.

Parameters:
NKEYS, 4, number of independent key channels
DEBOUNCE_TICKS, 4, consecutive opposite-value samples required to flip a debounced level (>=1)
REPEAT_DELAY, 16, sample ticks from press to first repeat pulse (>=1)
REPEAT_RATE, 4, sample ticks between subsequent repeat pulses (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
clk_N  input  1  divided clock from the divider; treated as asynchronous data
keys_raw  input  NKEYS  raw button pins, 1 = pressed, asynchronous
key_level  output  NKEYS  debounced key state
key_press  output  NKEYS  one-clk pulse on debounced 0->1 edge
key_repeat  output  NKEYS  one-clk pulse on each auto-repeat while held

Behaviour:
- One clock, `clk`. `rst` is asynchronous, active-high.
- While `rst` is high, or on its deassertion, these are all 0:
  - every synchronizer flop and every counter;
  - the edge register;
  - key_level, key_press, key_repeat.
- All channel FSMs start in IDLE.
- Strobe generation:
  - `clk_N` passes through a 2-FF synchronizer, then a delay flop.
  - `tick` = synced & ~delayed.
  - `tick` is high exactly one clk cycle per `clk_N` rising edge, 3 clk cycles after that edge.
  - No tick is generated for the first synced value after reset, because delayed resets to 0 and synced starts at 0.
- Each `keys_raw` bit passes through its own 2-FF synchronizer. The sample used on a tick is the synchronized value in the tick cycle.
- Debounce, per channel, evaluated only in tick cycles:
  - If sample == key_level, `dcnt` <= 0.
  - Otherwise `dcnt` increments. When the incremented value equals DEBOUNCE_TICKS, key_level toggles and `dcnt` <= 0.
  - With DEBOUNCE_TICKS=1, the level follows each sample on the next tick.
- FSM per channel: IDLE, DELAY, REPEAT. `rcnt` is the repeat counter. Transitions take effect the clk cycle after the tick.
  - IDLE:
    - On a debounced rise, key_press <= 1 for one cycle, `rcnt` <= 0, go to DELAY.
  - DELAY, on each tick while the level stays 1:
    - `rcnt` increments.
    - When `rcnt`+1 == REPEAT_DELAY: key_repeat <= 1 for one cycle, `rcnt` <= 0, go to REPEAT.
  - REPEAT, on each tick while the level stays 1:
    - `rcnt` increments.
    - When `rcnt`+1 == REPEAT_RATE: key_repeat pulse, `rcnt` <= 0.
  - In DELAY or REPEAT, a debounced fall goes to IDLE. The fall produces no pulse and clears `rcnt`. It also suppresses any repeat that would fire on the same tick, because the fall has priority.
- Pulse outputs are registered and deassert on the next clk cycle regardless of tick.
- Channels are independent. Simultaneous presses on several keys pulse in the same cycle.
- Counter widths are $clog2(max+1) of the respective parameter. Counters never exceed their terminal value.
- `rst` asserted mid-hold:
  - returns everything to reset values immediately;
  - after release, a still-held key must re-debounce, taking DEBOUNCE_TICKS ticks, and then produce a fresh key_press.

Decomposition:
- Shared package `tetris_io_pkg`:
  - key state enum {IDLE, DELAY, REPEAT};
  - key index constants KEY_LEFT=0, KEY_RIGHT=1, KEY_ROT=2, KEY_DROP=3;
  - default tick constants.
- Sub-module `key_channel`: one debouncer plus FSM, taking `tick` and one synced bit. It is instantiated NKEYS times in a generate loop.
- The top-level owns the synchronizers and `tick` generation.

Test Plan:
1. Reset with keys_raw=4'b0001 held throughout; release rst; drive `clk_N` rising edges. Required: no outputs for 3 ticks, then key_level[0]=1 and a single key_press[0] pulse in the clk cycle after the 4th tick (DEBOUNCE_TICKS=4).
2. Bounce on key 1, samples 1,0,1,1,1,1 across ticks. Required: counter cleared by the 0; key_level[1] rises only after the 6th tick; exactly one key_press.
3. Hold key 2 for 40 ticks. Required: first key_repeat 16 ticks after the press tick, then at +4, +8, ...; 6 repeats total by tick 40; each pulse exactly 1 clk wide.
4. Release key 2 in REPEAT with the level falling on the tick that would fire a repeat. Required: no repeat pulse, key_level low, FSM IDLE.
5. Press keys 0 and 3 on the same tick. Required: key_press=4'b1001 in a single cycle; independent repeat trains.
6. Assert rst for 2 cycles mid-hold (key 0 in DELAY), keeping the key held. Required: all outputs 0 immediately; after release, re-debounce over 4 ticks, then a fresh key_press[0].
